// File: rtl/gate_stim_checker_if.sv
// Connection bundle between the gate stimulus checker and its environment:
// sweep control/results plus the drive and observe lines of the gate block.
interface gate_stim_checker_if #(
  parameter int ERR_W = 3
);
  logic             start;
  logic             a_drv;
  logic             b_drv;
  logic             out_not;
  logic             out_and;
  logic             out_nand;
  logic             out_or;
  logic             out_nor;
  logic             out_xor;
  logic             out_xnor;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  modport master (
    input  start, out_not, out_and, out_nand, out_or, out_nor, out_xor, out_xnor,
    output a_drv, b_drv, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, out_not, out_and, out_nand, out_or, out_nor, out_xor, out_xnor,
    input  a_drv, b_drv, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_stim_checker.sv
// Sweeps a/b through 00,01,10,11, waits SETTLE_CYCLES per vector, then checks
// the seven observed gate outputs against the truth table.
module gate_stim_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic clk,
  input  logic rst,
  gate_stim_checker_if.master bus
);
  localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_q;
  logic             pass_q;
  logic [6:0]       obs, exp_obs;
  logic             mismatch;

  function automatic logic [6:0] exp_of(input logic [1:0] v);
    case (v)
      2'd0:    exp_of = 7'b1010101;
      2'd1:    exp_of = 7'b1011010;
      2'd2:    exp_of = 7'b0011010;
      default: exp_of = 7'b0101001;
    endcase
  endfunction

  assign obs     = {bus.out_not, bus.out_and, bus.out_nand, bus.out_or,
                    bus.out_nor, bus.out_xor, bus.out_xnor};
  assign exp_obs = exp_of(vec);

  // An unknown compare result falls through to the mismatch default.
  always_comb begin
    mismatch = 1'b1;
    if (obs == exp_obs) mismatch = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vec == 2'd3) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.a_drv     = vec[1];
    bus.b_drv     = vec[0];
    bus.pass      = pass_q;
    bus.err_count = err_q;
    bus.fail_vec  = fail_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec    <= 2'd0;
      cnt    <= '0;
      err_q  <= '0;
      fail_q <= 4'd0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          vec    <= 2'd0;
          cnt    <= '0;
          err_q  <= '0;
          fail_q <= 4'd0;
          pass_q <= 1'b0;
        end
        SETTLE: if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        SAMPLE: begin
          cnt <= '0;
          if (mismatch) begin
            fail_q[vec] <= 1'b1;
            if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
          end
          // Last vector: fold this sample into the verdict held through DONE.
          if (vec != 2'd3) vec <= vec + 2'd1;
          else             pass_q <= ~mismatch && (fail_q == 4'd0);
        end
        default: ;
      endcase
    end
  end
endmodule
